sevenseg_scan_decoder: RTL and testbench
========================================

// Module: sevenseg_scan_decoder
// PURPOSE
//  Receive side of the 7-segment display interface: samples a time-multiplexed
//  NDIG-digit display bus (segment lines abc_defg + one-hot digit select).
//  Qualifies each digit pattern as stable, inverts the hex-to-segment code back
//  to a nibble, and assembles the digits into one word with a frame strobe.
//  Used for display loopback checks and board-level readback of scanned displays.
// PARAMETERS
//  NDIG        4   number of multiplexed digits (>=1); value width = 4*NDIG
//  STABLE_CYC  4   synced cycles {an,seg} must hold unchanged before capture (>=1)
// PORTS
//  clk          in   1        single clock, rising edge
//  reset_n      in   1        asynchronous, active-low reset
//  seg          in   7        segment lines, bit6=a .. bit0=g, 1 = lit; async to clk
//  an           in   NDIG     digit select, 1 = digit active; bit i = digit i (i=0 is LS nibble)
//  clr_err      in   1        synchronous clear of err_pat/err_sel (and err_count)
//  value        out  4*NDIG   assembled word; nibble i = last decoded digit i
//  frame_valid  out  1        1-cycle pulse: every digit captured since last pulse
//  digit_valid  out  NDIG     digits captured in the current frame
//  err_pat      out  1        sticky: a stable pattern was not in the code table
//  err_sel      out  1        sticky: a stable an had >1 bit set
//  err_count    out  8        saturating count of bad-pattern captures (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset_n=0, async assert, sync deassert is the system's job): value=0,
//    frame_valid=0, digit_valid=0, err_pat=0, err_sel=0, err_count=0, FSM=IDLE, cnt=0.
//  - seg and an each pass through a 2-flop synchroniser; all logic below uses synced values.
//  - Code table (seg -> nibble): 7E:0 30:1 6D:2 79:3 33:4 5B:5 5F:6 70:7 7F:8 73:9
//    77:A 1F:B 4E:C 3D:D 4F:E 47:F. Any other seg value is a bad pattern.
//  - Change = synced {an,seg} differs from its value one cycle earlier.
//  - FSM: IDLE -> SETTLE on change (cnt<=0). SETTLE: change -> cnt<=0, stay;
//    else cnt++; when cnt==STABLE_CYC-1 with no change -> capture, go CAPTURED.
//    CAPTURED: hold, no further capture; change -> SETTLE (cnt<=0).
//    STABLE_CYC=1: capture on first unchanged cycle after the change.
//  - Capture rules (registered on the capture edge):
//    an==0 (blanking): nothing written, no error.
//    an not one-hot: err_sel<=1, nothing written.
//    an one-hot (digit i), seg in table: value nibble i <= code, digit_valid[i]<=1;
//    recapture of digit i in same frame overwrites (latest wins).
//    an one-hot, seg not in table: err_pat<=1, err_count++ (if enabled), nibble i
//    and digit_valid[i] unchanged.
//  - Frame: cycle after digit_valid becomes all-ones, frame_valid=1 for exactly one
//    cycle and digit_valid<=0 on that same edge; value holds until next capture.
//  - Latency: pins stable from edge k -> synced change seen at k+2 -> capture edge
//    k+2+STABLE_CYC -> frame_valid (if last digit) at k+3+STABLE_CYC.
//  - clr_err concurrent with a new error: error wins (flag stays/sets to 1).
//  - reset_n low mid-frame: all state discarded; next frame requires all digits anew.
// CONFIGURATION
//  SEVENSEG_SCAN_DEC_ERRCNT_EN defined: err_count is an 8-bit counter, +1 per
//    bad-pattern capture, saturates at 255, cleared by clr_err (clr_err and an
//    increment in the same cycle -> 1).
//  Not defined: err_count tied to 8'd0; no counter flops; err_pat unaffected.
// TESTING
//  1. NDIG=4, scan digits 0..3 with seg 7E,30,6D,79, each held 10 cycles ->
//     one frame_valid pulse, value=16'h3210, digit_valid back to 0.
//  2. Dwell on a digit with seg 7F for STABLE_CYC-1 synced cycles, then switch ->
//     no capture; full STABLE_CYC dwell -> capture at k+2+STABLE_CYC exactly.
//  3. Digit 2 with seg 7'h00 (not in table) -> err_pat=1, nibble 2 kept,
//     err_count=1 (EN) / 0 (no EN); pulse clr_err -> err_pat=0.
//  4. an=4'b0110 stable -> err_sel=1, no write; an=0 -> no write, no error.
//  5. Digit 1 captured as 77 then 1F before frame completes; finish 0,2,3 ->
//     value nibble1=B. Assert reset_n mid-frame -> all outputs 0 immediately.
//  6. EN build: 300 bad captures -> err_count=255 (saturated).

Source files
------------

// File: rtl/sevenseg_scan_decoder.sv
// Receive side of a multiplexed 7-segment display bus: qualifies stable digit patterns,
// decodes them back to nibbles and assembles a word. SEVENSEG_SCAN_DEC_ERRCNT_EN adds err_count.
module sevenseg_scan_decoder #(
   parameter int unsigned NDIG       = 4,
   parameter int unsigned STABLE_CYC = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [6:0]          seg,
   input  logic [NDIG-1:0]     an,
   input  logic                clr_err,
   output logic [4*NDIG-1:0]   value,
   output logic                frame_valid,
   output logic [NDIG-1:0]     digit_valid,
   output logic                err_pat,
   output logic                err_sel,
   output logic [7:0]          err_count
);

   localparam int unsigned VAL_W = 4 * NDIG;
   localparam int unsigned BUS_W = NDIG + 7;
   localparam int unsigned CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETTLE   = 2'd1,
      CAPTURED = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [6:0]          seg_s1_q, seg_s2_q;
   logic [NDIG-1:0]     an_s1_q, an_s2_q;
   logic [BUS_W-1:0]    last_q;
   logic [VAL_W-1:0]    value_q, value_d;
   logic [NDIG-1:0]     digit_valid_q, digit_valid_d;
   logic                frame_valid_q, frame_valid_d;
   logic                err_pat_q, err_pat_d;
   logic                err_sel_q, err_sel_d;

   logic                change_c;
   logic                capture_c;
   logic                onehot_c;
   logic                pat_ok_c;
   logic [3:0]          nib_c;

   // Inverse of the hex-to-segment table; bit 4 flags a legal pattern.
   function automatic logic [4:0] decode(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'h7E:   r = 5'h10;
         7'h30:   r = 5'h11;
         7'h6D:   r = 5'h12;
         7'h79:   r = 5'h13;
         7'h33:   r = 5'h14;
         7'h5B:   r = 5'h15;
         7'h5F:   r = 5'h16;
         7'h70:   r = 5'h17;
         7'h7F:   r = 5'h18;
         7'h73:   r = 5'h19;
         7'h77:   r = 5'h1A;
         7'h1F:   r = 5'h1B;
         7'h4E:   r = 5'h1C;
         7'h3D:   r = 5'h1D;
         7'h4F:   r = 5'h1E;
         7'h47:   r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   assign change_c = ({an_s2_q, seg_s2_q} != last_q);
   assign onehot_c = (an_s2_q != '0) && ((an_s2_q & (an_s2_q - NDIG'(1))) == '0);
   assign {pat_ok_c, nib_c} = decode(seg_s2_q);

   // Stability qualifier: capture once per settled {an,seg} pattern.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      capture_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (change_c) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end
         end
         SETTLE: begin
            if (change_c) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_W'(STABLE_CYC - 1)) begin
               capture_c = 1'b1;
               state_d   = CAPTURED;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         CAPTURED: begin
            if (change_c) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture, frame assembly and sticky error flags.
   always_comb begin
      value_d       = value_q;
      digit_valid_d = digit_valid_q;
      frame_valid_d = &digit_valid_q;
      err_pat_d     = err_pat_q & ~clr_err;
      err_sel_d     = err_sel_q & ~clr_err;
      if (frame_valid_d) begin
         digit_valid_d = '0;
      end
      if (capture_c) begin
         if ((an_s2_q != '0) && !onehot_c) begin
            err_sel_d = 1'b1;
         end else if (onehot_c) begin
            if (pat_ok_c) begin
               for (int i = 0; i < NDIG; i++) begin
                  if (an_s2_q[i]) begin
                     value_d[4*i +: 4] = nib_c;
                     digit_valid_d[i]  = 1'b1;
                  end
               end
            end else begin
               err_pat_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         seg_s1_q      <= '0;
         seg_s2_q      <= '0;
         an_s1_q       <= '0;
         an_s2_q       <= '0;
         last_q        <= '0;
         value_q       <= '0;
         digit_valid_q <= '0;
         frame_valid_q <= 1'b0;
         err_pat_q     <= 1'b0;
         err_sel_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         seg_s1_q      <= seg;
         seg_s2_q      <= seg_s1_q;
         an_s1_q       <= an;
         an_s2_q       <= an_s1_q;
         last_q        <= {an_s2_q, seg_s2_q};
         value_q       <= value_d;
         digit_valid_q <= digit_valid_d;
         frame_valid_q <= frame_valid_d;
         err_pat_q     <= err_pat_d;
         err_sel_q     <= err_sel_d;
      end
   end

`ifdef SEVENSEG_SCAN_DEC_ERRCNT_EN
   logic [7:0] err_count_q, err_count_d;
   logic       bad_pat_c;

   assign bad_pat_c = capture_c && onehot_c && !pat_ok_c;

   // Clear first so a same-cycle bad capture still counts as 1; saturate at 255.
   always_comb begin
      err_count_d = clr_err ? 8'd0 : err_count_q;
      if (bad_pat_c && (err_count_d != 8'hFF)) begin
         err_count_d = err_count_d + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_count_q <= 8'd0;
      end else begin
         err_count_q <= err_count_d;
      end
   end

   assign err_count = err_count_q;
`else
   assign err_count = 8'd0;
`endif

   assign value       = value_q;
   assign frame_valid = frame_valid_q;
   assign digit_valid = digit_valid_q;
   assign err_pat     = err_pat_q;
   assign err_sel     = err_sel_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Scoreboard bench for sevenseg_scan_decoder (NDIG=4, STABLE_CYC=4): expected frame words
// are queued by the stimulus and checked by a frame monitor; flags are checked inline.
module tb_sevenseg_scan_decoder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [6:0]  seg = 7'h00;
   logic [3:0]  an = 4'h0;
   logic        clr_err = 1'b0;
   logic [15:0] value;
   logic        frame_valid;
   logic [3:0]  digit_valid;
   logic        err_pat;
   logic        err_sel;
   logic [7:0]  err_count;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_q[$];

   sevenseg_scan_decoder #(.NDIG(4), .STABLE_CYC(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .seg         (seg),
      .an          (an),
      .clr_err     (clr_err),
      .value       (value),
      .frame_valid (frame_valid),
      .digit_valid (digit_valid),
      .err_pat     (err_pat),
      .err_sel     (err_sel),
      .err_count   (err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Put a pattern on the pins just after an edge, then hold for n more edges.
   task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
      @(posedge clk);
      #1;
      an  = a;
      seg = s;
      repeat (n) @(posedge clk);
   endtask

   task automatic pulse_clr();
      @(posedge clk);
      #1 clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
   endtask

   // Frame monitor: every frame_valid pulse must match the oldest queued word.
   always @(negedge clk) begin
      if (frame_valid) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL frame_unexpected: got value %0h, expected no frame at %0t", value, $time);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (value !== e) begin
               n_err++;
               $display("FAIL frame_value: got %0h, expected %0h at %0t", value, e, $time);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, expected end of stimulus");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_value", 32'(value), 32'h0);
      check("reset_flags", {frame_valid, digit_valid, err_pat, err_sel, err_count}, 32'h0);
      @(negedge clk) reset_n = 1'b1;

      // Plain scan of four digits.
      show(4'b0001, 7'h7E, 10);
      show(4'b0010, 7'h30, 10);
      show(4'b0100, 7'h6D, 10);
      exp_q.push_back(16'h3210);
      show(4'b1000, 7'h79, 10);
      show(4'b0000, 7'h00, 10);
      @(negedge clk);
      check("t1_digit_valid", 32'(digit_valid), 32'h0);
      check("t1_value_hold", 32'(value), 32'h3210);

      // One edge short of a stable dwell: no capture.
      show(4'b0010, 7'h7F, 3);
      show(4'b0000, 7'h00, 10);
      @(negedge clk);
      check("t2_short_dv", 32'(digit_valid), 32'h0);
      check("t2_short_value", 32'(value), 32'h3210);

      // Full dwell: capture lands exactly at k+2+STABLE_CYC.
      @(posedge clk);
      #1;
      an  = 4'b0001;
      seg = 7'h7F;
      @(posedge clk);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("t2_before_capture", 32'(digit_valid), 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("t2_at_capture", 32'(digit_valid), 32'h1);
      check("t2_value", 32'(value), 32'h3218);

      // Bad pattern on digit 2.
      show(4'b0100, 7'h00, 10);
      @(negedge clk);
      check("t3_err_pat", 32'(err_pat), 32'h1);
      check("t3_value_kept", 32'(value), 32'h3218);
      check("t3_dv_kept", 32'(digit_valid), 32'h1);
`ifdef SEVENSEG_SCAN_DEC_ERRCNT_EN
      check("t3_err_count", 32'(err_count), 32'h1);
`else
      check("t3_err_count", 32'(err_count), 32'h0);
`endif
      pulse_clr();
      @(negedge clk);
      check("t3_err_pat_clr", 32'(err_pat), 32'h0);
      check("t3_err_count_clr", 32'(err_count), 32'h0);

      // Multi-hot select, then blanking.
      show(4'b0110, 7'h30, 10);
      @(negedge clk);
      check("t4_err_sel", 32'(err_sel), 32'h1);
      check("t4_no_write", {16'(value), 12'h0, digit_valid}, {16'h3218, 12'h0, 4'h1});
      pulse_clr();
      show(4'b0000, 7'h7E, 10);
      @(negedge clk);
      check("t4_blank_flags", {err_pat, err_sel}, 32'h0);
      check("t4_blank_no_write", {16'(value), 12'h0, digit_valid}, {16'h3218, 12'h0, 4'h1});

      // Recapture of digit 1 in the same frame: latest wins.
      show(4'b0010, 7'h77, 10);
      show(4'b0010, 7'h1F, 10);
      show(4'b0100, 7'h7E, 10);
      exp_q.push_back(16'hE0B8);
      show(4'b1000, 7'h4F, 10);
      show(4'b0000, 7'h00, 10);
      @(negedge clk);
      check("t5_dv_after_frame", 32'(digit_valid), 32'h0);

      // Reset mid-frame discards partial progress.
      show(4'b0001, 7'h30, 10);
      @(negedge clk);
      check("t5_partial_dv", 32'(digit_valid), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      check("t5_reset_value", 32'(value), 32'h0);
      check("t5_reset_flags", {frame_valid, digit_valid, err_pat, err_sel, err_count}, 32'h0);
      an  = 4'h0;
      seg = 7'h00;
      @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      show(4'b0010, 7'h33, 10);
      show(4'b0100, 7'h5B, 10);
      show(4'b1000, 7'h5F, 10);
      @(negedge clk);
      check("t5_no_frame_yet", 32'(digit_valid), 32'hE);
      exp_q.push_back(16'h6547);
      show(4'b0001, 7'h70, 10);
      show(4'b0000, 7'h00, 10);

`ifdef SEVENSEG_SCAN_DEC_ERRCNT_EN
      // Saturation of the bad-pattern counter.
      for (int i = 0; i < 150; i++) begin
         show(4'b0001, 7'h00, 6);
         show(4'b0001, 7'h01, 6);
      end
      show(4'b0000, 7'h00, 10);
      @(negedge clk);
      check("t6_err_count_sat", 32'(err_count), 32'hFF);
`endif

      @(negedge clk);
      check("frames_outstanding", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
